// File: rtl/cdb_arbiter.sv
// Grants up to two producer results per cycle onto CDB1/CDB2; CDB_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority.
// Latency: grant (req_ready) is combinational, broadcast is registered one cycle later; rdy low or rollback withholds every grant.
module cdb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ROB_ID_WIDTH = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rdy,
    input  logic                             rollback_flag,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ROB_ID_WIDTH-1:0]  req_rob_id,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_result,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             cdb1_valid,
    output logic [ROB_ID_WIDTH-1:0]          cdb1_rob_id,
    output logic [DATA_WIDTH-1:0]            cdb1_result,
    output logic                             cdb2_valid,
    output logic [ROB_ID_WIDTH-1:0]          cdb2_rob_id,
    output logic [DATA_WIDTH-1:0]            cdb2_result
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] scan_start;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    assign scan_start = ptr_q;
`else
    assign scan_start = '0;
`endif

    logic                    cdb1_valid_q;
    logic [ROB_ID_WIDTH-1:0] cdb1_rob_id_q;
    logic [DATA_WIDTH-1:0]   cdb1_result_q;
    logic                    cdb2_valid_q;
    logic [ROB_ID_WIDTH-1:0] cdb2_rob_id_q;
    logic [DATA_WIDTH-1:0]   cdb2_result_q;

    logic                    found1;
    logic                    found2;
    logic [PTR_W-1:0]        g1_idx;
    logic [PTR_W-1:0]        g2_idx;
    logic [PTR_W-1:0]        idx;
    logic                    enable;
    logic                    grant1;
    logic                    grant2;
    logic [ROB_ID_WIDTH-1:0] tag1;
    logic [ROB_ID_WIDTH-1:0] tag2;
    logic [DATA_WIDTH-1:0]   res1;
    logic [DATA_WIDTH-1:0]   res2;

    // Walk the requesters once, starting at scan_start, wrapping by explicit compare
    // so non-power-of-two NUM_REQ never visits an unused index.
    always_comb begin
        found1 = 1'b0;
        found2 = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        idx    = scan_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[idx]) begin
                if (!found1) begin
                    found1 = 1'b1;
                    g1_idx = idx;
                end else if (!found2) begin
                    found2 = 1'b1;
                    g2_idx = idx;
                end
            end
            idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
        end
    end

    assign enable = rdy & ~rollback_flag & ~rst;
    assign grant1 = enable & found1;
    assign grant2 = enable & found2;

    always_comb begin
        req_ready = '0;
        tag1      = '0;
        tag2      = '0;
        res1      = '0;
        res2      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g1_idx == PTR_W'(i)) begin
                tag1 = req_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
                res1 = req_result[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = req_ready[i] | grant1;
            end
            if (g2_idx == PTR_W'(i)) begin
                tag2 = req_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
                res2 = req_result[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = req_ready[i] | grant2;
            end
        end
    end

`ifdef CDB_ARB_ROUND_ROBIN_EN
    // Resume the scan just past whichever producer was granted last.
    always_comb begin
        ptr_d = ptr_q;
        if (found2) begin
            ptr_d = (g2_idx == LAST_IDX) ? '0 : g2_idx + PTR_W'(1);
        end else if (found1) begin
            ptr_d = (g1_idx == LAST_IDX) ? '0 : g1_idx + PTR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb1_valid_q  <= 1'b0;
            cdb1_rob_id_q <= '0;
            cdb1_result_q <= '0;
            cdb2_valid_q  <= 1'b0;
            cdb2_rob_id_q <= '0;
            cdb2_result_q <= '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            ptr_q         <= '0;
`endif
        end else if (rollback_flag) begin
            cdb1_valid_q  <= 1'b0;
            cdb2_valid_q  <= 1'b0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            ptr_q         <= '0;
`endif
        end else if (!rdy) begin
            cdb1_valid_q  <= 1'b0;
            cdb2_valid_q  <= 1'b0;
        end else begin
            // Idle buses keep their last tag/result; only valid drops.
            cdb1_valid_q <= found1;
            cdb2_valid_q <= found2;
            if (found1) begin
                cdb1_rob_id_q <= tag1;
                cdb1_result_q <= res1;
            end
            if (found2) begin
                cdb2_rob_id_q <= tag2;
                cdb2_result_q <= res2;
            end
`ifdef CDB_ARB_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign cdb1_valid  = cdb1_valid_q;
    assign cdb1_rob_id = cdb1_rob_id_q;
    assign cdb1_result = cdb1_result_q;
    assign cdb2_valid  = cdb2_valid_q;
    assign cdb2_rob_id = cdb2_rob_id_q;
    assign cdb2_result = cdb2_result_q;

endmodule
